// File: rtl/dcache_responder.sv
// -----------------------------------------------------------------------------
// dcache_responder
//   Responder end of the core's data-memory port. Direct-mapped, write-through,
//   no-write-allocate data cache with multi-word lines. Read misses refill a
//   whole line from main memory over a valid/ready request channel followed by
//   LINE_WORDS streamed response beats (word 0 first). Stores are written
//   through to memory as single masked word writes.
//
//   Optional build macro: DCACHE_WBUF_EN
//     Defined   -> one-entry write buffer. A store that finds the buffer empty
//                  completes without stalling, and the buffer issues the write
//                  request in the background. A read miss waits for the buffer
//                  to drain before refilling, which keeps memory order intact.
//     Undefined -> every store stalls the CPU until memory accepts the write.
//
//   Ports
//     clk, reset        rising-edge clock, asynchronous active-low reset
//     dcache_addr       CPU byte address (bits [1:0] ignored)
//     dcache_re         CPU read request
//     dcache_we         CPU byte-lane write enables (nonzero = store)
//     dcache_din        CPU store data, lane aligned
//     dcache_dout       load data; holds its value when no load completes
//     stall             CPU freezes and holds its request while high
//     mem_req_*         request to memory (rw=0 line read, rw=1 masked write)
//     mem_resp_*        refill beats from memory
// -----------------------------------------------------------------------------
module dcache_responder #(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rw,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_W   = 30 - OFF_W - IDX_W;
  localparam int IDX_LSB = 2 + OFF_W;
  localparam int TAG_LSB = 2 + OFF_W + IDX_W;

  localparam logic [31:0]      WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0]      LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
  localparam logic [OFF_W-1:0] BEAT_ONE  = OFF_W'(1);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_LOOKUP      = 3'd1;
  localparam logic [2:0] S_REFILL_REQ  = 3'd2;
  localparam logic [2:0] S_REFILL_DATA = 3'd3;
  localparam logic [2:0] S_DONE        = 3'd4;
`ifdef DCACHE_WBUF_EN
  localparam logic [2:0] S_WAIT_WB     = 3'd5;
`else
  localparam logic [2:0] S_WRITE_REQ   = 3'd5;
`endif

  // Merge the enabled byte lanes of new_w over old_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = mask[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    end
    return res;
  endfunction

  // Storage arrays (data and tags carry no reset; valid bits do).
  logic [31:0]      data_q [LINES*LINE_WORDS];
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_q, valid_d;

  logic [2:0]       state_q, state_d, nxt_s;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       we_q, we_d;
  logic [31:0]      din_q, din_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic [31:0]      dout_q;

  logic [IDX_W-1:0]       idx_s;
  logic [OFF_W-1:0]       off_s;
  logic [TAG_W-1:0]       tag_s;
  logic [IDX_W+OFF_W-1:0] word_idx_s;
  logic [31:0]            rd_word_s;
  logic                   hit_s;
  logic                   is_store_s;
  logic                   stall_s;
  logic                   capture_s;
  logic                   rd_done_s;
  logic                   arr_we_s;
  logic [IDX_W+OFF_W-1:0] arr_widx_s;
  logic [31:0]            arr_wdata_s;
  logic                   tag_we_s;

`ifdef DCACHE_WBUF_EN
  logic        push_s;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [3:0]  wb_mask_q, wb_mask_d;
`endif

  // Lookup of the captured request against the arrays.
  always_comb begin
    idx_s      = addr_q[IDX_LSB +: IDX_W];
    off_s      = addr_q[2 +: OFF_W];
    tag_s      = addr_q[TAG_LSB +: TAG_W];
    word_idx_s = {idx_s, off_s};
    rd_word_s  = data_q[word_idx_s];
    hit_s      = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
    is_store_s = (we_q != 4'b0000);
  end

  // Controller: next state, stall, array write strobes and request capture.
  always_comb begin
    nxt_s       = state_q;
    stall_s     = 1'b0;
    rd_done_s   = 1'b0;
    valid_d     = valid_q;
    beat_d      = beat_q;
    arr_we_s    = 1'b0;
    arr_widx_s  = word_idx_s;
    arr_wdata_s = merge_bytes(rd_word_s, din_q, we_q);
    tag_we_s    = 1'b0;
`ifdef DCACHE_WBUF_EN
    push_s      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        nxt_s = S_IDLE;
      end
      S_LOOKUP: begin
        if (is_store_s) begin
`ifdef DCACHE_WBUF_EN
          if (!wb_valid_q) begin
            push_s   = 1'b1;
            arr_we_s = hit_s;
            nxt_s    = S_IDLE;
          end else begin
            stall_s = 1'b1;
            nxt_s   = S_WAIT_WB;
          end
`else
          arr_we_s = hit_s;
          stall_s  = 1'b1;
          nxt_s    = S_WRITE_REQ;
`endif
        end else if (hit_s) begin
          rd_done_s = 1'b1;
          nxt_s     = S_IDLE;
        end else begin
          // The line is overwritten during refill, so drop it up front.
          stall_s        = 1'b1;
          valid_d[idx_s] = 1'b0;
`ifdef DCACHE_WBUF_EN
          nxt_s = wb_valid_q ? S_WAIT_WB : S_REFILL_REQ;
`else
          nxt_s = S_REFILL_REQ;
`endif
        end
      end
      S_REFILL_REQ: begin
        stall_s = 1'b1;
        beat_d  = {OFF_W{1'b0}};
        nxt_s   = mem_req_ready ? S_REFILL_DATA : S_REFILL_REQ;
      end
      S_REFILL_DATA: begin
        stall_s = 1'b1;
        if (mem_resp_valid) begin
          arr_we_s    = 1'b1;
          arr_widx_s  = {idx_s, beat_q};
          arr_wdata_s = mem_resp_data;
          beat_d      = beat_q + BEAT_ONE;
          if (beat_q == LAST_BEAT) begin
            tag_we_s       = 1'b1;
            valid_d[idx_s] = 1'b1;
            nxt_s          = S_DONE;
          end else begin
            nxt_s = S_REFILL_DATA;
          end
        end else begin
          nxt_s = S_REFILL_DATA;
        end
      end
      S_DONE: begin
        rd_done_s = !is_store_s;
        nxt_s     = S_IDLE;
      end
`ifdef DCACHE_WBUF_EN
      S_WAIT_WB: begin
        // Held-off store or read miss waits here until the buffer is empty.
        stall_s = 1'b1;
        if (!wb_valid_q) begin
          if (is_store_s) begin
            push_s   = 1'b1;
            arr_we_s = hit_s;
            nxt_s    = S_DONE;
          end else begin
            nxt_s = S_REFILL_REQ;
          end
        end else begin
          nxt_s = S_WAIT_WB;
        end
      end
`else
      S_WRITE_REQ: begin
        stall_s = 1'b1;
        nxt_s   = mem_req_ready ? S_DONE : S_WRITE_REQ;
      end
`endif
      default: begin
        nxt_s = S_IDLE;
      end
    endcase

    // A new request is taken on any edge where the CPU is not stalled.
    capture_s = !stall_s && (dcache_re || (dcache_we != 4'b0000));
    state_d   = capture_s ? S_LOOKUP : nxt_s;
    if (capture_s) begin
      addr_d = dcache_addr;
      we_d   = dcache_we;
      din_d  = dcache_din;
    end else begin
      addr_d = addr_q;
      we_d   = we_q;
      din_d  = din_q;
    end
  end

  assign stall       = stall_s;
  assign dcache_dout = rd_done_s ? rd_word_s : dout_q;

  // Controller registers, captured request, load-data hold and valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= 32'd0;
      we_q    <= 4'd0;
      din_q   <= 32'd0;
      beat_q  <= {OFF_W{1'b0}};
      dout_q  <= 32'd0;
      valid_q <= {LINES{1'b0}};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      din_q   <= din_d;
      beat_q  <= beat_d;
      dout_q  <= dcache_dout;
      valid_q <= valid_d;
    end
  end

  // Data and tag array writes.
  always_ff @(posedge clk) begin
    if (arr_we_s) begin
      data_q[arr_widx_s] <= arr_wdata_s;
    end
    if (tag_we_s) begin
      tag_q[idx_s] <= tag_s;
    end
  end

`ifdef DCACHE_WBUF_EN
  // Write buffer: loaded by a store, emptied when memory accepts it.
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wb_mask_d  = wb_mask_q;
    if (push_s) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = addr_q & WORD_MASK;
      wb_data_d  = din_q;
      wb_mask_d  = we_q;
    end else if (wb_valid_q && mem_req_ready) begin
      wb_valid_d = 1'b0;
    end else begin
      wb_valid_d = wb_valid_q;
    end
  end

  // Write buffer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= 32'd0;
      wb_data_q  <= 32'd0;
      wb_mask_q  <= 4'd0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      wb_mask_q  <= wb_mask_d;
    end
  end
`endif

  // Memory request channel, driven only from registered state so it stays
  // stable while waiting for ready.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = 32'd0;
    mem_req_data  = 32'd0;
    mem_req_mask  = 4'd0;
`ifdef DCACHE_WBUF_EN
    if (wb_valid_q) begin
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b1;
      mem_req_addr  = wb_addr_q;
      mem_req_data  = wb_data_q;
      mem_req_mask  = wb_mask_q;
    end else if (state_q == S_REFILL_REQ) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = addr_q & LINE_MASK;
    end else begin
      mem_req_valid = 1'b0;
    end
`else
    if (state_q == S_WRITE_REQ) begin
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b1;
      mem_req_addr  = addr_q & WORD_MASK;
      mem_req_data  = din_q;
      mem_req_mask  = we_q;
    end else if (state_q == S_REFILL_REQ) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = addr_q & LINE_MASK;
    end else begin
      mem_req_valid = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_dcache_responder.sv
// -----------------------------------------------------------------------------
// tb_dcache_responder
//   Self-checking bench for dcache_responder. A CPU-side driver issues one
//   access at a time; a memory model answers requests with random latency.
//   Expected load data comes from an architectural memory image updated by
//   every CPU store; expected hit/miss comes from a per-line record of which
//   line address was last brought in by a load; expected memory traffic is a
//   queue of requests predicted at issue time and matched in order.
// -----------------------------------------------------------------------------
module tb_dcache_responder;

  localparam int          LINES      = 64;
  localparam int          LINE_WORDS = 4;
  localparam logic [31:0] LINE_BYTES = 32'(LINE_WORDS * 4);
  localparam logic [31:0] LINE_MASK  = ~(LINE_BYTES - 32'd1);
  localparam logic [31:0] WAY_SPAN   = 32'(LINES * LINE_WORDS * 4);

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dcache_addr;
  logic        dcache_re;
  logic [3:0]  dcache_we;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rw;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  always #5 clk = ~clk;

  dcache_responder #(.LINES(LINES), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .reset(reset),
    .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
    .dcache_din(dcache_din), .dcache_dout(dcache_dout), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] mem_q   [logic [29:0]];  // what memory actually holds
  logic [31:0] ref_mem [logic [29:0]];  // what the CPU should observe
  bit          ref_valid [LINES];
  logic [31:0] ref_line  [LINES];

  int fixed_dly  = -1;
  bit hold_ready = 1'b0;
  int beats_sent = 0;
  int reads_acc  = 0;

  function automatic logic [31:0] default_word(input logic [29:0] w);
    return {w[15:0] ^ 16'hC35A, w[15:0]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    return mem_q.exists(w) ? mem_q[w] : default_word(w);
  endfunction

  function automatic logic [31:0] ref_word(input logic [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : default_word(w);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = m[b] ? n[b*8 +: 8] : o[b*8 +: 8];
    return r;
  endfunction

  // ---------------- memory model ----------------
  initial begin : mem_model
    logic        r_rw;
    logic [31:0] r_addr, r_data;
    logic [3:0]  r_mask;
    int          dly;
    req_t        e;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'd0;
    forever begin
      @(negedge clk);
      if (reset && mem_req_valid) begin
        r_rw   = mem_req_rw;
        r_addr = mem_req_addr;
        r_data = mem_req_data;
        r_mask = mem_req_mask;
        dly    = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
        while (dly > 0 || hold_ready) begin
          @(negedge clk);
          if (dly > 0) dly--;
          check_eq("req_stable", {mem_req_valid, mem_req_rw, mem_req_mask, mem_req_addr},
                   {1'b1, r_rw, r_mask, r_addr});
          if (r_rw) check_eq("req_data_stable", mem_req_data, r_data);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check_eq("req_was_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("req_rw", r_rw, e.rw);
          check_eq("req_addr", r_addr, e.addr);
          if (e.rw) begin
            check_eq("req_data", r_data, e.data);
            check_eq("req_mask", r_mask, e.mask);
          end
        end
        if (r_rw) begin
          mem_q[r_addr[31:2]] = merge(mem_word(r_addr[31:2]), r_data, r_mask);
        end else begin
          reads_acc++;
          for (int i = 0; i < LINE_WORDS; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(r_addr[31:2] + 30'(i));
            beats_sent++;
            @(negedge clk);
            mem_resp_valid = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- CPU side ----------------
  task automatic cpu_access(input logic [31:0] a, input logic rd, input logic [3:0] we,
                            input logic [31:0] d, output logic [31:0] got, output int stalls);
    @(negedge clk);
    dcache_addr = a;
    dcache_re   = rd;
    dcache_we   = we;
    dcache_din  = d;
    @(negedge clk);  // lookup cycle
    dcache_re = 1'b0;
    dcache_we = 4'd0;
    stalls    = 0;
    while (stall === 1'b1 && stalls < 400) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 400) check_eq("access_timeout", stall, 1'b0);
    got = dcache_dout;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] got);
    int stalls;
    int idx;
    bit hit;
    idx = int'((a / LINE_BYTES) % LINES);
    hit = ref_valid[idx] && (ref_line[idx] == (a & LINE_MASK));
    if (!hit) exp_q.push_back('{1'b0, a & LINE_MASK, 32'd0, 4'd0});
    cpu_access(a, 1'b1, 4'd0, 32'd0, got, stalls);
    check_eq("load_data", got, ref_word(a[31:2]));
    if (hit) begin
      check_eq("hit_no_stall", stalls, 0);
    end else begin
      check_eq("miss_stalled", stalls > 0, 1);
      check_eq("beats_before_done", beats_sent, reads_acc * LINE_WORDS);
    end
    ref_valid[idx] = 1'b1;
    ref_line[idx]  = a & LINE_MASK;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d,
                          input logic also_re, output int stalls);
    logic [31:0] got;
    exp_q.push_back('{1'b1, a & 32'hFFFF_FFFC, d, we});
    ref_mem[a[31:2]] = merge(ref_word(a[31:2]), d, we);
    cpu_access(a, also_re, we, d, got, stalls);
`ifndef DCACHE_WBUF_EN
    check_eq("store_stalled", stalls > 0, 1);
`endif
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] got;
    logic [31:0] a;
    int          st;
    reset       = 1'b0;
    dcache_addr = 32'd0;
    dcache_re   = 1'b0;
    dcache_we   = 4'd0;
    dcache_din  = 32'd0;
    for (int i = 0; i < LINES; i++) begin
      ref_valid[i] = 1'b0;
      ref_line[i]  = 32'd0;
    end
    for (int i = 0; i < 4; i++) begin
      mem_q[30'h40 + 30'(i)]   = 32'hA0 + 32'(i);
      ref_mem[30'h40 + 30'(i)] = 32'hA0 + 32'(i);
    end

    repeat (3) @(negedge clk);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_req_valid", mem_req_valid, 1'b0);
    check_eq("rst_dout", dcache_dout, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("post_rst_stall", stall, 1'b0);
    check_eq("post_rst_req_valid", mem_req_valid, 1'b0);

    // Read miss, ready after 2 cycles, then hit in the same line.
    fixed_dly = 2;
    do_read(32'h100, got);
    check_eq("miss_0x100", got, 32'hA0);
    do_read(32'h104, got);
    check_eq("hit_0x104", got, 32'hA1);

    // Back-to-back hits: second request presented during the first lookup.
    @(negedge clk);
    dcache_addr = 32'h104;
    dcache_re   = 1'b1;
    @(negedge clk);
    check_eq("b2b_stall_1", stall, 1'b0);
    check_eq("b2b_dout_1", dcache_dout, 32'hA1);
    dcache_addr = 32'h10C;
    @(negedge clk);
    dcache_re = 1'b0;
    check_eq("b2b_stall_2", stall, 1'b0);
    check_eq("b2b_dout_2", dcache_dout, 32'hA3);

    // Partial store hit, merged halves.
    do_store(32'h108, 4'b0011, 32'hDEADBEEF, 1'b0, st);
    do_read(32'h108, got);
    check_eq("store_merge_0x108", got, 32'h0000_BEEF);

    // Conflict in the same index.
    do_read(32'h100 + WAY_SPAN, got);
    do_read(32'h100, got);
    check_eq("conflict_refill_0x100", got, 32'hA0);

    // Store miss: no allocate.
    do_store(32'h2000, 4'b1111, 32'h1234_5678, 1'b1, st);
    do_read(32'h2000, got);
    check_eq("store_miss_then_read", got, 32'h1234_5678);

`ifdef DCACHE_WBUF_EN
    hold_ready = 1'b1;
    do_store(32'h100, 4'b1111, 32'h1111_2222, 1'b0, st);
    check_eq("wbuf_store1_no_stall", st, 0);
    do_read(32'h104, got);
    fork
      begin
        repeat (6) @(negedge clk);
        hold_ready = 1'b0;
      end
    join_none
    do_store(32'h10C, 4'b1111, 32'h3333_4444, 1'b0, st);
    check_eq("wbuf_store2_stalled", st >= 4, 1);
    do_read(32'h10C, got);
    check_eq("wbuf_store2_data", got, 32'h3333_4444);
`endif

    // Randomized mix over a few lines and ways.
    fixed_dly = -1;
    for (int k = 0; k < 300; k++) begin
      a = 32'($urandom_range(0, 3)) * WAY_SPAN
        + 32'($urandom_range(0, 7)) * LINE_BYTES
        + 32'($urandom_range(0, LINE_WORDS - 1)) * 32'd4
        + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        do_store(a, 4'($urandom_range(1, 15)), $urandom, 1'($urandom_range(0, 1)), st);
      end else begin
        do_read(a, got);
      end
    end

    for (int w = 0; w < 200 && exp_q.size() > 0; w++) @(negedge clk);
    check_eq("all_reqs_seen", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
